// File: rtl/ram_loader.sv
// ram_loader: streams a 16-byte program image into a 16x8 RAM while holding
// the CPU off the RAM port.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra checksum byte follows the 16 data bytes. ERR is
//   raised if (sum of the 16 bytes + checksum byte) mod 256 is non-zero.
//   When undefined, there is no CHECK state and ERR is tied to 0.
//
// Ports
//   CLK, RESET              clock; asynchronous active-high reset
//   LOAD_START              start a load (taken only in IDLE)
//   BYTE_VALID/BYTE_DATA    upstream byte stream
//   BYTE_READY              high in cycles where a byte is accepted
//   CPU_ADDR/CPU_DIN/CPU_RI CPU-side RAM access (passed through when idle)
//   RAM_ADDR/RAM_DIN/RAM_RI RAM pins
//   BUSY, CPU_HALT          loader owns the RAM port (identical)
//   DONE, ERR               sticky load status
module ram_loader (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD_START,
  input  logic       BYTE_VALID,
  input  logic [7:0] BYTE_DATA,
  output logic       BYTE_READY,
  input  logic [3:0] CPU_ADDR,
  input  logic [7:0] CPU_DIN,
  input  logic       CPU_RI,
  output logic [3:0] RAM_ADDR,
  output logic [7:0] RAM_DIN,
  output logic       RAM_RI,
  output logic       BUSY,
  output logic       CPU_HALT,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_FIN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       wr_en;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic [7:0] sum_plus_byte;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    done_d     = done_q;
    BYTE_READY = 1'b0;
    BUSY       = 1'b0;
    wr_en      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d         = sum_q;
    err_d         = err_q;
    sum_plus_byte = sum_q + BYTE_DATA;
`endif

    case (state_q)
      S_IDLE: begin
        if (LOAD_START) begin
          cnt_d   = 4'd0;
          done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
          err_d   = 1'b0;
`endif
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_VALID) begin
          data_d  = BYTE_DATA;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_plus_byte;
`endif
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        BUSY  = 1'b1;
        wr_en = 1'b1;
        if (cnt_q == 4'hF) begin
          // Counter parks at 15; it is cleared by the next accepted start.
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          done_d  = 1'b1;
          state_d = S_FIN;
`endif
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_RECV;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_VALID) begin
          // Checksum byte is consumed here and never written to RAM.
          err_d   = (sum_plus_byte != 8'd0);
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
`endif

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM port mux: loader owns the pins while busy, CPU otherwise.
  always_comb begin
    if (BUSY) begin
      RAM_ADDR = cnt_q;
      RAM_DIN  = data_q;
      RAM_RI   = wr_en;
    end else begin
      RAM_ADDR = CPU_ADDR;
      RAM_DIN  = CPU_DIN;
      RAM_RI   = CPU_RI;
    end
  end

  assign CPU_HALT = BUSY;
  assign DONE     = done_q;

`ifdef LOADER_CHECKSUM_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       LOAD_START;
  logic       BYTE_VALID;
  logic [7:0] BYTE_DATA;
  logic       BYTE_READY;
  logic [3:0] CPU_ADDR;
  logic [7:0] CPU_DIN;
  logic       CPU_RI;
  logic [3:0] RAM_ADDR;
  logic [7:0] RAM_DIN;
  logic       RAM_RI;
  logic       BUSY;
  logic       CPU_HALT;
  logic       DONE;
  logic       ERR;

  ram_loader dut (
    .CLK(CLK), .RESET(RESET), .LOAD_START(LOAD_START),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_RI(CPU_RI),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_RI(RAM_RI),
    .BUSY(BUSY), .CPU_HALT(CPU_HALT), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural 16x8 RAM attached to the RAM pins, plus a count of loader writes.
  logic [7:0] ram_m [16];
  int         load_pulses = 0;
  always @(posedge CLK) begin
    if (RAM_RI === 1'b1) ram_m[RAM_ADDR] <= RAM_DIN;
    if (RAM_RI === 1'b1 && BUSY === 1'b1) load_pulses <= load_pulses + 1;
  end

  logic [7:0] img [16];
  logic [7:0] chk_byte;
  logic       exp_err;

  // Reference model: the k-th accepted byte lands at address k in the cycle
  // right after it is accepted; after 16 writes (plus the checksum byte when
  // enabled) the loader reports DONE for one FIN cycle and then idles.
  task automatic run_load(input int vpct, input int restart_at, input int abort_at,
                          input bit cpu_noise, input bit start_in_fin, output int fin_cyc);
    int wr, cyc;
    bit pend, fin, chk_done, exp_ready;
    logic [7:0] s;
    logic [7:0] snap;
    s = chk_byte;
    for (int i = 0; i < 16; i++) s = s + img[i];
    exp_err = CHK && (s != 8'd0);
    wr = 0; cyc = 0; pend = 0; fin = 0; chk_done = 0; exp_ready = 0; fin_cyc = 0;

    @(negedge CLK);
    CPU_RI = 1'b0;
    LOAD_START = 1'b1;
    BYTE_VALID = 1'b1;           // byte landing in IDLE must be ignored
    BYTE_DATA = 8'hEE;
    @(negedge CLK);
    LOAD_START = 1'b0;

    while (!fin && cyc < 600) begin
      cyc++;
      if (pend) begin
        n_cmp++;
        if (RAM_RI !== 1'b1 || RAM_ADDR !== 4'(wr) || RAM_DIN !== img[wr] ||
            BUSY !== 1'b1 || BYTE_READY !== 1'b0) begin
          n_bad++;
          $display("FAIL write[%0d]: got ri=%b addr=%h din=%h busy=%b rdy=%b want ri=1 addr=%h din=%h busy=1 rdy=0",
                   wr, RAM_RI, RAM_ADDR, RAM_DIN, BUSY, BYTE_READY, 4'(wr), img[wr]);
        end
        wr++; pend = 0; exp_ready = 0;
      end else if (wr == 16 && (!CHK || chk_done)) begin
        n_cmp++;
        if (BUSY !== 1'b0 || CPU_HALT !== 1'b0 || DONE !== 1'b1 || ERR !== exp_err ||
            BYTE_READY !== 1'b0 || RAM_RI !== CPU_RI) begin
          n_bad++;
          $display("FAIL fin: got busy=%b halt=%b done=%b err=%b rdy=%b ri=%b want busy=0 halt=0 done=1 err=%b rdy=0 ri=%b",
                   BUSY, CPU_HALT, DONE, ERR, BYTE_READY, RAM_RI, exp_err, CPU_RI);
        end
        fin = 1; fin_cyc = cyc;
      end else begin
        if (abort_at >= 0 && wr == abort_at) begin
          snap = ram_m[wr];
          CPU_RI = 1'b0;
          RESET = 1'b1;
          #1;
          n_cmp++;
          if (BUSY !== 1'b0 || CPU_HALT !== 1'b0 || BYTE_READY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_now: got busy=%b halt=%b rdy=%b done=%b err=%b want all 0",
                     BUSY, CPU_HALT, BYTE_READY, DONE, ERR);
          end
          @(negedge CLK);
          RESET = 1'b0; BYTE_VALID = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (RAM_RI !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
              n_bad++;
              $display("FAIL abort_idle[%0d]: got ri=%b busy=%b done=%b want 0 0 0", k, RAM_RI, BUSY, DONE);
            end
          end
          n_cmp++;
          if (ram_m[abort_at] !== snap || load_pulses < 0) begin
            n_bad++;
            $display("FAIL abort_ram: got ram[%0d]=%h want %h", abort_at, ram_m[abort_at], snap);
          end
          fin_cyc = -1;
          return;
        end
        n_cmp++;
        if (BYTE_READY !== 1'b1 || BUSY !== 1'b1 || CPU_HALT !== 1'b1 || RAM_RI !== 1'b0 ||
            DONE !== 1'b0 || ERR !== 1'b0) begin
          n_bad++;
          $display("FAIL recv[%0d]: got rdy=%b busy=%b halt=%b ri=%b done=%b err=%b want 1 1 1 0 0 0",
                   wr, BYTE_READY, BUSY, CPU_HALT, RAM_RI, DONE, ERR);
        end
        exp_ready = 1;
      end

      if (!fin) begin
        if (cpu_noise) begin
          CPU_ADDR = 4'($urandom); CPU_DIN = 8'($urandom); CPU_RI = 1'($urandom_range(0, 3) != 0);
        end
        LOAD_START = (restart_at >= 0 && wr == restart_at) ? 1'b1 : 1'b0;
        BYTE_VALID = ($urandom_range(1, 100) <= vpct);
        BYTE_DATA = 8'($urandom);
        if (exp_ready && BYTE_VALID) begin
          if (wr < 16) begin BYTE_DATA = img[wr]; pend = 1; end
          else begin BYTE_DATA = chk_byte; chk_done = 1; end
        end
        @(negedge CLK);
      end
    end

    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout: got no FIN after %0d cycles want FIN", cyc);
      return;
    end
    // FIN cycle: return to IDLE regardless of LOAD_START.
    CPU_RI = 1'b0;
    BYTE_VALID = 1'b0;
    LOAD_START = start_in_fin;
    @(negedge CLK);
    LOAD_START = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b1 || BYTE_READY !== 1'b0 || ERR !== exp_err) begin
      n_bad++;
      $display("FAIL post_fin: got busy=%b done=%b rdy=%b err=%b want busy=0 done=1 rdy=0 err=%b",
               BUSY, DONE, BYTE_READY, ERR, exp_err);
    end
    n_cmp++;
    for (int i = 0; i < 16; i++) begin
      if (ram_m[i] !== img[i]) begin
        n_bad++;
        $display("FAIL ram_image[%0d]: got %h want %h", i, ram_m[i], img[i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; LOAD_START = 1'b1; BYTE_VALID = 1'b1; BYTE_DATA = 8'h33;
    CPU_ADDR = 4'h0; CPU_DIN = 8'h00; CPU_RI = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0 || CPU_HALT !== 1'b0 || BYTE_READY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b halt=%b rdy=%b done=%b err=%b want all 0",
               BUSY, CPU_HALT, BYTE_READY, DONE, ERR);
    end
    LOAD_START = 1'b0; BYTE_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    // Clear the behavioural RAM through the CPU path.
    for (int a = 0; a < 16; a++) begin
      CPU_ADDR = 4'(a); CPU_DIN = 8'h00; CPU_RI = 1'b1;
      @(negedge CLK);
    end
    CPU_RI = 1'b0;
  endtask

  task automatic test_cpu_passthrough();
    logic [3:0] a; logic [7:0] d; logic r;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin a = 4'h5; d = 8'hA5; r = 1'b1; end
      else begin a = 4'($urandom); d = 8'($urandom); r = 1'($urandom); end
      CPU_ADDR = a; CPU_DIN = d; CPU_RI = r;
      #1;
      n_cmp++;
      if (RAM_ADDR !== a || RAM_DIN !== d || RAM_RI !== r) begin
        n_bad++;
        $display("FAIL passthrough[%0d]: got %h/%h/%b want %h/%h/%b", i, RAM_ADDR, RAM_DIN, RAM_RI, a, d, r);
      end
      @(negedge CLK);
    end
    CPU_RI = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int fc, p0;
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    chk_byte = 8'h88;
    p0 = load_pulses;
    run_load(100, -1, -1, 1'b0, 1'b0, fc);
    n_cmp++;
    if (fc !== (CHK ? 34 : 33)) begin
      n_bad++;
      $display("FAIL b2b_latency: got FIN at cycle %0d want %0d", fc, CHK ? 34 : 33);
    end
    n_cmp++;
    if (load_pulses - p0 !== 16) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 16", load_pulses - p0);
    end
  endtask

  task automatic test_random_gaps();
    int fc, p0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      chk_byte = 8'($urandom);
      p0 = load_pulses;
      run_load(30 + 30 * r, -1, -1, 1'b1, 1'b1, fc);
      n_cmp++;
      if (load_pulses - p0 !== 16) begin
        n_bad++;
        $display("FAIL gaps_pulses[%0d]: got %0d want 16", r, load_pulses - p0);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int fc, p0;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    chk_byte = 8'($urandom);
    p0 = load_pulses;
    run_load(100, 3, -1, 1'b1, 1'b0, fc);
    n_cmp++;
    if (load_pulses - p0 !== 16 || fc !== (CHK ? 34 : 33)) begin
      n_bad++;
      $display("FAIL restart: got pulses=%0d fin=%0d want 16 and %0d", load_pulses - p0, fc, CHK ? 34 : 33);
    end
  endtask

  task automatic test_reset_midload();
    int fc, p0;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    img[8] = ~ram_m[8];
    chk_byte = 8'h00;
    p0 = load_pulses;
    run_load(100, -1, 8, 1'b0, 1'b0, fc);
    n_cmp++;
    if (fc !== -1 || load_pulses - p0 !== 8) begin
      n_bad++;
      $display("FAIL midload_abort: got fin=%0d pulses=%0d want -1 and 8", fc, load_pulses - p0);
    end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      if (ram_m[i] !== img[i]) begin
        n_bad++;
        $display("FAIL midload_kept[%0d]: got %h want %h", i, ram_m[i], img[i]);
        break;
      end
    end
  endtask

  task automatic test_checksum();
    int fc;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'h01;
      chk_byte = (t == 0) ? 8'hF0 : 8'hF1;
      run_load(100, -1, -1, 1'b0, 1'b0, fc);
      n_cmp++;
      if (DONE !== 1'b1 || ERR !== (CHK && t == 1)) begin
        n_bad++;
        $display("FAIL checksum[%0d]: got done=%b err=%b want done=1 err=%b", t, DONE, ERR, CHK && t == 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_back_to_back();
    test_random_gaps();
    test_restart_ignored();
    test_reset_midload();
    test_checksum();
    test_cpu_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
